// File: rtl/ps2_rx_pkg.sv
// Shared types and constants for the PS/2 device-to-host frame receiver.
package ps2_rx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RECV  = 2'd1,
    ST_CHECK = 2'd2
  } ps2_state_e;

  localparam logic [7:0] PS2_EXT_PREFIX   = 8'hE0;
  localparam logic [7:0] PS2_BREAK_PREFIX = 8'hF0;

endpackage

// File: rtl/ps2_rx_frame_filter.sv
// ps2_line_filter: synchroniser plus run-length deglitcher for one PS/2 line,
// with a registered falling-edge strobe of the filtered line.
module ps2_line_filter #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned FILT_LEN    = 4
) (
  input  logic clk,
  input  logic resetN,
  input  logic line_raw,
  output logic line_f,
  output logic fall_edge
);

  localparam int unsigned CNT_W = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;

  logic [SYNC_STAGES-1:0] sync_q;
  logic [CNT_W-1:0]       cnt_q;
  logic                   smp;
  logic                   flip_c;

  assign smp    = sync_q[SYNC_STAGES-1];
  // FILT_LEN-th consecutive sample that disagrees with the filtered level
  assign flip_c = (smp != line_f) && (cnt_q == CNT_W'(FILT_LEN - 1));

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      sync_q    <= '1;
      cnt_q     <= '0;
      line_f    <= 1'b1;
      fall_edge <= 1'b0;
    end else begin
      sync_q    <= {sync_q[SYNC_STAGES-2:0], line_raw};
      fall_edge <= flip_c && line_f;
      if (smp == line_f || flip_c) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
      if (flip_c) begin
        line_f <= smp;
      end
    end
  end

endmodule

// File: rtl/ps2_rx_frame.sv
// PS/2 frame receiver: start/data/parity/stop checking with a stall watchdog.
// Define PS2_RX_EXT_CODE_EN to fold E0/F0 prefix bytes into is_ext/is_break.
module ps2_rx_frame
  import ps2_rx_pkg::*;
#(
  parameter int unsigned DATA_BITS   = 8,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned FILT_LEN    = 4,
  parameter int unsigned TIMEOUT_CYC = 50000,
  parameter int unsigned PARITY_ODD  = 1
) (
  input  logic                 clk,
  input  logic                 resetN,
  input  logic                 kbd_clk,
  input  logic                 kbd_dat,
  output logic [DATA_BITS-1:0] dout,
  output logic                 dout_new,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 timeout_err,
  output logic                 busy,
  output logic                 is_ext,
  output logic                 is_break
);

  localparam int unsigned BC_W = $clog2(DATA_BITS + 4);
  localparam int unsigned SH_W = DATA_BITS + 2;
  localparam int unsigned WD_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;

  ps2_state_e           state, state_nxt;
  logic [BC_W-1:0]      cnt, cnt_nxt;
  logic [SH_W-1:0]      shreg, shreg_nxt;
  logic [WD_W-1:0]      wdog, wdog_nxt;
  logic                 to_pend, to_pend_nxt;
  logic [DATA_BITS-1:0] dout_nxt, payload;
  logic                 dout_new_nxt, parity_nxt, frame_nxt, timeout_nxt;
  logic                 fall_edge, dat_f, kclk_f_unused, kdat_fall_unused;
  logic                 par_bad_c, prefix_c;

  ps2_line_filter #(.SYNC_STAGES(SYNC_STAGES), .FILT_LEN(FILT_LEN)) u_clk_filt (
    .clk(clk), .resetN(resetN), .line_raw(kbd_clk),
    .line_f(kclk_f_unused), .fall_edge(fall_edge)
  );

  ps2_line_filter #(.SYNC_STAGES(SYNC_STAGES), .FILT_LEN(FILT_LEN)) u_dat_filt (
    .clk(clk), .resetN(resetN), .line_raw(kbd_dat),
    .line_f(dat_f), .fall_edge(kdat_fall_unused)
  );

  // shreg holds {stop, parity, data} once the stop bit has been shifted in
  assign payload   = shreg[DATA_BITS-1:0];
  assign par_bad_c = (^shreg[DATA_BITS:0]) != 1'(PARITY_ODD);

  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    shreg_nxt    = shreg;
    wdog_nxt     = wdog;
    to_pend_nxt  = 1'b0;
    dout_nxt     = dout;
    dout_new_nxt = 1'b0;
    parity_nxt   = 1'b0;
    frame_nxt    = 1'b0;
    timeout_nxt  = to_pend;
    unique case (state)
      ST_IDLE: begin
        if (fall_edge && !dat_f) begin
          state_nxt = ST_RECV;
          cnt_nxt   = BC_W'(1);
          wdog_nxt  = '0;
        end
      end
      ST_RECV: begin
        if (fall_edge) begin
          shreg_nxt = {dat_f, shreg[SH_W-1:1]};
          cnt_nxt   = cnt + BC_W'(1);
          wdog_nxt  = '0;
          if (cnt == BC_W'(DATA_BITS + 2)) begin
            state_nxt = ST_CHECK;
          end
        end else if (wdog == WD_W'(TIMEOUT_CYC - 1)) begin
          state_nxt   = ST_IDLE;
          to_pend_nxt = 1'b1;
        end else begin
          wdog_nxt = wdog + WD_W'(1);
        end
      end
      ST_CHECK: begin
        state_nxt = ST_IDLE;
        if (!shreg[SH_W-1]) begin
          frame_nxt = 1'b1;
        end else if (par_bad_c) begin
          parity_nxt = 1'b1;
        end else if (!prefix_c) begin
          dout_nxt     = payload;
          dout_new_nxt = 1'b1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      shreg       <= '0;
      wdog        <= '0;
      to_pend     <= 1'b0;
      dout        <= '0;
      dout_new    <= 1'b0;
      parity_err  <= 1'b0;
      frame_err   <= 1'b0;
      timeout_err <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      shreg       <= shreg_nxt;
      wdog        <= wdog_nxt;
      to_pend     <= to_pend_nxt;
      dout        <= dout_nxt;
      dout_new    <= dout_new_nxt;
      parity_err  <= parity_nxt;
      frame_err   <= frame_nxt;
      timeout_err <= timeout_nxt;
      busy        <= (state_nxt != ST_IDLE);
    end
  end

`ifdef PS2_RX_EXT_CODE_EN
  logic ext_q, brk_q, ext_nxt, brk_nxt, is_ext_nxt, is_break_nxt, good_c;

  assign prefix_c = (payload == PS2_EXT_PREFIX) || (payload == PS2_BREAK_PREFIX);
  assign good_c   = (state == ST_CHECK) && shreg[SH_W-1] && !par_bad_c;

  // Sticky prefix flags; any error or a delivered byte clears them
  always_comb begin
    ext_nxt      = ext_q;
    brk_nxt      = brk_q;
    is_ext_nxt   = 1'b0;
    is_break_nxt = 1'b0;
    if (frame_nxt || parity_nxt || to_pend_nxt) begin
      ext_nxt = 1'b0;
      brk_nxt = 1'b0;
    end else if (dout_new_nxt) begin
      is_ext_nxt   = ext_q;
      is_break_nxt = brk_q;
      ext_nxt      = 1'b0;
      brk_nxt      = 1'b0;
    end else if (good_c && payload == PS2_EXT_PREFIX) begin
      ext_nxt = 1'b1;
    end else if (good_c && payload == PS2_BREAK_PREFIX) begin
      brk_nxt = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      ext_q    <= 1'b0;
      brk_q    <= 1'b0;
      is_ext   <= 1'b0;
      is_break <= 1'b0;
    end else begin
      ext_q    <= ext_nxt;
      brk_q    <= brk_nxt;
      is_ext   <= is_ext_nxt;
      is_break <= is_break_nxt;
    end
  end
`else
  assign prefix_c = 1'b0;
  assign is_ext   = 1'b0;
  assign is_break = 1'b0;
`endif

endmodule
